mem_arbiter: RTL and testbench

- Sequences the single-ported RAM between the instruction-fetch port (read-only) and the data port (LW/SW traffic driven by dREN/dWEN from decode).
- Registered grant FSM; one requester owns the RAM until ramstate reports ACCESS, ERROR, a drop, or a watchdog timeout.
- Sits between the datapath request logic and the RAM model.
- Default policy is strict data priority so LW/SW are never starved by fetch.

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/arb_watchdog.sv | 36 +++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, RAM handshake states and the memory
// arbiter grant states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Status reported by the RAM model for the access currently driven.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Which requester currently owns the RAM.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DATA = 2'd1,
        ARB_INST = 2'd2
    } arb_state_t;

    // True when the RAM is still working on (or has not started) an access.
    function automatic logic ram_pending(input ramstate_t s);
        return (s == FREE) || (s == BUSY);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts cycles a grant spends waiting on the RAM and
// raises a terminal-count pulse on the cycle the budget is exhausted.
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("arb_watchdog: TIMEOUT_CYCLES must be in 2..255");
    end

    localparam logic [7:0] TERMINAL = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;

    // Terminal count fires only on a counting cycle, so a completing or
    // failing access never doubles as a timeout.
    assign tc_o = en_i && (count_q == TERMINAL);

    // Cycle counter: cleared while idle, advances on each waiting cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= 8'd0;
        end else if (clr_i) begin
            count_q <= 8'd0;
        end else if (en_i) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares the single-ported RAM between instruction fetch
// and the data port. Data has strict priority by default; defining
// MEM_ARB_FAIR_EN lets a waiting fetch through after MAX_DSTREAK
// consecutive data grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_DSTREAK    = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    if (MAX_DSTREAK < 1 || MAX_DSTREAK > 15) begin : g_bad_streak
        $error("mem_arbiter: MAX_DSTREAK must be in 1..15");
    end

    arb_state_t state_q;
    logic       arb_err_q;
    ramstate_t  ram_st;
    logic       d_req;
    logic       granted;
    logic       owner_req;
    logic       done;
    logic       fault;
    logic       wd_en;
    logic       wd_tc;
    logic       inst_turn;

    assign ram_st    = ramstate_t'(ramstate);
    assign d_req     = dREN | dWEN;
    assign granted   = (state_q != ARB_IDLE);
    assign owner_req = (state_q == ARB_DATA) ? d_req :
                       (state_q == ARB_INST) ? iREN : 1'b0;

    // A dropped request never completes or faults, even if the RAM says so.
    assign done  = granted && owner_req && (ram_st == ACCESS);
    assign wd_en = granted && owner_req && ram_pending(ram_st);
    assign fault = (granted && owner_req && (ram_st == ERROR)) || wd_tc;

    // Read data is a straight pass-through; the wait flags qualify it.
    assign iload   = ramload;
    assign dload   = ramload;
    assign arb_err = arb_err_q;

    arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (CLK),
        .rst_n_i (nRST),
        .clr_i   (state_q == ARB_IDLE),
        .en_i    (wd_en),
        .tc_o    (wd_tc)
    );

`ifdef MEM_ARB_FAIR_EN
    logic [3:0] streak_q;

    // A starved fetch takes the next grant once the data streak is full.
    assign inst_turn = iREN && (streak_q >= 4'(MAX_DSTREAK));

    // Count data completions that happened while a fetch was waiting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak_q <= 4'd0;
        end else if (done && (state_q == ARB_DATA)) begin
            if (!iREN) begin
                streak_q <= 4'd0;
            end else if (streak_q != 4'hF) begin
                streak_q <= streak_q + 4'd1;
            end
        end else if (done && (state_q == ARB_INST)) begin
            streak_q <= 4'd0;
        end
    end
`else
    assign inst_turn = 1'b0;
`endif

    // Grant FSM plus the sticky error flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ARB_IDLE;
            arb_err_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (d_req && !inst_turn) begin
                        state_q <= ARB_DATA;
                    end else if (iREN) begin
                        state_q <= ARB_INST;
                    end
                end
                ARB_DATA, ARB_INST: begin
                    if (!owner_req || done || fault) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
            if (fault) begin
                arb_err_q <= 1'b1;
            end
        end
    end

    // RAM drive and wait flags follow the owner's live request lines.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_q)
            ARB_DATA: begin
                ramaddr  = daddr;
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramstore = dstore;
                dwait    = !done;
            end
            ARB_INST: begin
                ramaddr  = iaddr;
                ramREN   = iREN;
                iwait    = !done;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Honours MEM_ARB_FAIR_EN when defined.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TO   = 64;
    localparam int MAXD = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = 32'd0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = 32'd0;
    logic [31:0] dstore = 32'd0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = 32'd0;
    logic [1:0]  ramstate;
    logic        arb_err;

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .MAX_DSTREAK(MAXD)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .arb_err(arb_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM responder: 'lat' BUSY cycles then ACCESS ----
    int          lat = 0;
    logic        rforce = 1'b0;
    logic [1:0]  rforced = 2'(FREE);
    int          rcnt = 0;

    always_comb begin
        ramstate = 2'(FREE);
        if (rforce) ramstate = rforced;
        else if (ramREN | ramWEN) ramstate = (rcnt >= lat) ? 2'(ACCESS) : 2'(BUSY);
    end

    always @(posedge CLK) begin
        if ((ramREN | ramWEN) && ramstate != 2'(ACCESS)) rcnt <= rcnt + 1;
        else rcnt <= 0;
    end

    // ---------------- Reference model: who owns the RAM, for how long ----
    int   m_owner = 0;   // 0 nobody, 1 data port, 2 fetch port
    int   m_cyc = 0;     // waiting cycles spent in current grant
    int   m_streak = 0;  // data completions while a fetch waited
    logic m_err = 1'b0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_owner <= 0; m_cyc <= 0; m_err <= 1'b0; m_streak <= 0;
        end else if (m_owner == 0) begin
            m_cyc <= 0;
            if ((dREN | dWEN) && !(FAIR && iREN && m_streak >= MAXD)) m_owner <= 1;
            else if (iREN) m_owner <= 2;
        end else if (!(m_owner == 1 ? (dREN | dWEN) : iREN)) begin
            m_owner <= 0;
        end else if (ramstate == 2'(ACCESS)) begin
            m_owner <= 0;
            if (m_owner == 2 || !iREN) m_streak <= 0;
            else if (m_streak < 15) m_streak <= m_streak + 1;
        end else if (ramstate == 2'(ERROR) || m_cyc == TO - 1) begin
            m_err <= 1'b1;
            m_owner <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    logic        e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store;

    always_comb begin
        e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'd0; e_store = 32'd0;
        e_iw = 1'b1; e_dw = 1'b1;
        if (nRST && m_owner == 1) begin
            e_addr = daddr; e_ren = dREN; e_wen = dWEN; e_store = dstore;
            e_dw = !((dREN | dWEN) && ramstate == 2'(ACCESS));
        end else if (nRST && m_owner == 2) begin
            e_addr = iaddr; e_ren = iREN;
            e_iw = !(iREN && ramstate == 2'(ACCESS));
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("m_iwait",    32'(iwait),    32'(e_iw));
        chk("m_dwait",    32'(dwait),    32'(e_dw));
        chk("m_ramREN",   32'(ramREN),   32'(e_ren));
        chk("m_ramWEN",   32'(ramWEN),   32'(e_wen));
        chk("m_ramaddr",  ramaddr,       e_addr);
        chk("m_ramstore", ramstore,      e_store);
        chk("m_iload",    iload,         ramload);
        chk("m_dload",    dload,         ramload);
        chk("m_arb_err",  32'(arb_err),  32'(m_err));
    end

    // ---------------- Directed stimulus ----------------
    task automatic adv();
        @(posedge CLK); #1;
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        rforce = 1'b0; lat = 0;
        adv(); adv();
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    initial begin : directed
        int   hi;
        int   errc;
        int   dn;
        bit   idone;
        int   olen;
        logic [31:0] obits;
        string ord;

        // Reset with both requests high.
        iREN = 1'b1; dREN = 1'b1;
        adv(); adv(); neg();
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_arb_err", 32'(arb_err), 32'd0);
        iREN = 1'b0; dREN = 1'b0;
        adv(); nRST = 1'b1;
        $display("txn reset: requests held off under reset");

        // Lone fetch, two BUSY cycles then ACCESS.
        adv();
        lat = 2; ramload = 32'h2002_0001; iaddr = 32'h0000_0040; iREN = 1'b1;
        neg(); chk("fetch_idle_ramREN", 32'(ramREN), 32'd0);
        adv(); neg();
        chk("fetch_ramaddr", ramaddr, 32'h40);
        chk("fetch_ramREN", 32'(ramREN), 32'd1);
        chk("fetch_busy1_iwait", 32'(iwait), 32'd1);
        adv(); neg(); chk("fetch_busy2_iwait", 32'(iwait), 32'd1);
        adv(); neg();
        chk("fetch_done_iwait", 32'(iwait), 32'd0);
        chk("fetch_iload", iload, 32'h2002_0001);
        adv(); iREN = 1'b0;
        neg();
        chk("fetch_after_ramREN", 32'(ramREN), 32'd0);
        chk("fetch_after_iwait", 32'(iwait), 32'd1);
        $display("txn fetch: addr=0x40 data=0x20020001");

        // Contention: write and fetch requested together.
        adv();
        lat = 0; iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1;
        daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        neg();
        adv(); neg();
        chk("cont_ramWEN", 32'(ramWEN), 32'd1);
        chk("cont_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("cont_ramaddr", ramaddr, 32'h80);
        chk("cont_dwait", 32'(dwait), 32'd0);
        chk("cont_iwait", 32'(iwait), 32'd1);
        adv(); dWEN = 1'b0;
        neg(); chk("cont_turn_ramREN", 32'(ramREN), 32'd0);
        adv(); neg();
        chk("cont_fetch_addr", ramaddr, 32'h44);
        chk("cont_fetch_iwait", 32'(iwait), 32'd0);
        adv(); iREN = 1'b0;
        $display("txn contention: data write first, fetch second");

        // RAM ERROR during a data read, then retry.
        rforce = 1'b1; rforced = 2'(BUSY); dREN = 1'b1; daddr = 32'h100;
        neg();
        adv(); neg(); chk("err_grant_ramREN", 32'(ramREN), 32'd1);
        adv(); rforced = 2'(ERROR);
        neg();
        chk("err_dwait", 32'(dwait), 32'd1);
        chk("err_not_yet", 32'(arb_err), 32'd0);
        adv(); rforce = 1'b0; lat = 0;
        neg();
        chk("err_sticky", 32'(arb_err), 32'd1);
        chk("err_idle_ramREN", 32'(ramREN), 32'd0);
        adv(); neg();
        chk("err_retry_dwait", 32'(dwait), 32'd0);
        chk("err_retry_sticky", 32'(arb_err), 32'd1);
        adv(); dREN = 1'b0;
        $display("txn error: retry completed, arb_err sticky");

        // Watchdog timeout with RAM stuck BUSY.
        do_reset();
        adv();
        rforce = 1'b1; rforced = 2'(BUSY); dREN = 1'b1;
        hi = 0; errc = -1;
        for (int k = 0; k < 200; k++) begin
            neg();
            if (arb_err) begin errc = k; break; end
            if (ramREN) hi++;
            adv();
        end
        chk("timeout_err_cycle", 32'(errc), 32'd65);
        chk("timeout_busy_cycles", 32'(hi), 32'd64);
        chk("timeout_released", 32'(ramREN), 32'd0);
        chk("timeout_dwait", 32'(dwait), 32'd1);
        adv(); dREN = 1'b0; rforce = 1'b0;
        $display("txn timeout: grant held %0d cycles, error seen at cycle %0d", hi, errc);

        // Request drop mid-grant.
        do_reset();
        adv();
        rforce = 1'b1; rforced = 2'(BUSY); dREN = 1'b1;
        neg();
        adv(); neg();
        adv(); neg(); chk("drop_granted_ramREN", 32'(ramREN), 32'd1);
        adv(); dREN = 1'b0;
        neg();
        chk("drop_ramREN", 32'(ramREN), 32'd0);
        chk("drop_dwait", 32'(dwait), 32'd1);
        chk("drop_arb_err", 32'(arb_err), 32'd0);
        adv(); neg(); chk("drop_idle_ramREN", 32'(ramREN), 32'd0);
        $display("txn drop: enables fell with the request");

        // Asynchronous reset in the middle of a grant.
        adv(); dREN = 1'b1;
        neg();
        adv(); neg(); chk("arst_granted_ramREN", 32'(ramREN), 32'd1);
        adv(); #1 nRST = 1'b0;
        #1;
        chk("arst_ramREN", 32'(ramREN), 32'd0);
        chk("arst_dwait", 32'(dwait), 32'd1);
        adv(); dREN = 1'b0; rforce = 1'b0;
        adv(); nRST = 1'b1;
        $display("txn async_reset: enables dropped immediately");

        // Back-to-back data reads with a fetch waiting.
        do_reset();
        adv();
        lat = 1; iREN = 1'b1; dREN = 1'b1; daddr = 32'h200; iaddr = 32'h300;
        dn = 0; idone = 1'b0; olen = 0; obits = 32'd0; ord = "";
        for (int k = 0; k < 300 && !(dn >= 6 && idone); k++) begin
            neg();
            if (!dwait) begin ord = {ord, "D"}; dn++; olen++; end
            if (!iwait) begin ord = {ord, "I"}; obits[olen] = 1'b1; idone = 1'b1; olen++; end
            adv();
            if (dn >= 6) dREN = 1'b0;
            if (idone) iREN = 1'b0;
        end
        chk("order_len", 32'(olen), 32'd7);
        chk("order_bits", obits, FAIR ? 32'h10 : 32'h40);
        $display("txn order: %s", ord);

        adv(); adv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
